// File: rtl/adder_pkg.sv
// Shared constants and the per-stage payload for the pipelined adder.
// Payload fields are sized to MAX_WIDTH; a given build uses the low WIDTH bits.
package adder_pkg;

    localparam int DEFAULT_WIDTH  = 16;
    localparam int DEFAULT_STAGES = 4;
    localparam int MAX_WIDTH      = 64;

    // One pipeline slot: partial sum built up chunk by chunk, the carry into
    // the next chunk, both operands (b already inverted for subtract), valid.
    typedef struct packed {
        logic [MAX_WIDTH-1:0] psum;
        logic                 carry;
        logic [MAX_WIDTH-1:0] a_rem;
        logic [MAX_WIDTH-1:0] b_rem;
        logic                 valid;
    } stage_t;

endpackage

// File: rtl/pipelined_adder_if.sv
// Handshake bus of the pipelined adder: operand side and result side.
// Optional macro PIPELINED_ADDER_OVF_EN adds the signed-overflow flag ovf.
interface pipelined_adder_if
    import adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef PIPELINED_ADDER_OVF_EN
    logic             ovf;
`endif

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout
`ifdef PIPELINED_ADDER_OVF_EN
        , input ovf
`endif
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout
`ifdef PIPELINED_ADDER_OVF_EN
        , output ovf
`endif
    );

endinterface

// File: rtl/adder_stage.sv
// One pipeline stage: adds the CHUNK-bit slice IDX of both operands plus the
// incoming carry, and registers the updated payload when enabled.
module adder_stage
    import adder_pkg::*;
#(
    parameter int CHUNK = 4,
    parameter int IDX   = 0
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   i_en,
    input  stage_t i_stage,
    output stage_t o_stage
);
    localparam int LO = IDX * CHUNK;

    logic [CHUNK:0] w_add;
    stage_t         w_next;
    stage_t         r_stage;

    // Chunk add; everything else in the payload passes through untouched.
    always_comb begin
        w_add = {1'b0, i_stage.a_rem[LO +: CHUNK]}
              + {1'b0, i_stage.b_rem[LO +: CHUNK]}
              + {{CHUNK{1'b0}}, i_stage.carry};
        w_next                  = i_stage;
        w_next.psum[LO +: CHUNK] = w_add[CHUNK-1:0];
        w_next.carry            = w_add[CHUNK];
    end

    // Stage register; the whole payload clears on reset because the last
    // stage drives sum/cout directly and those must read zero after reset.
    always_ff @(posedge clk) begin
        if (!rst_n)
            r_stage <= '0;
        else if (i_en)
            r_stage <= w_next;
    end

    assign o_stage = r_stage;

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined add/subtract with valid/ready handshake; one CHUNK-wide slice of
// the carry chain per stage, all stages advancing together.
// Optional macro PIPELINED_ADDER_OVF_EN adds the signed-overflow output ovf.
module pipelined_adder
    import adder_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int STAGES = DEFAULT_STAGES
) (
    input  logic               clk,
    input  logic               rst_n,
    pipelined_adder_if.slave   bus
);
    localparam int CHUNK = WIDTH / STAGES;

    if ((WIDTH % STAGES) != 0 || WIDTH > MAX_WIDTH) begin : g_bad_cfg
        $error("pipelined_adder: WIDTH must be a multiple of STAGES and <= MAX_WIDTH");
    end

    logic   w_advance;
    stage_t w_stage_in;
    stage_t w_stage [STAGES];
    stage_t w_last;
    logic   w_unused_bits;

    // The whole pipe moves whenever the output slot is empty or being drained.
    assign w_advance    = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = w_advance;

    // Stage 0 payload: subtract is a + ~b + 1, so cin is replaced by 1.
    always_comb begin
        w_stage_in                   = '0;
        w_stage_in.a_rem[WIDTH-1:0]  = bus.a;
        w_stage_in.b_rem[WIDTH-1:0]  = bus.sub ? ~bus.b : bus.b;
        w_stage_in.carry             = bus.sub ? 1'b1 : bus.cin;
        w_stage_in.valid             = bus.in_valid;
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_first
            adder_stage #(.CHUNK(CHUNK), .IDX(k)) u_stage (
                .clk     (clk),
                .rst_n   (rst_n),
                .i_en    (w_advance),
                .i_stage (w_stage_in),
                .o_stage (w_stage[k])
            );
        end else begin : g_next
            adder_stage #(.CHUNK(CHUNK), .IDX(k)) u_stage (
                .clk     (clk),
                .rst_n   (rst_n),
                .i_en    (w_advance),
                .i_stage (w_stage[k-1]),
                .o_stage (w_stage[k])
            );
        end
    end

    assign w_last        = w_stage[STAGES-1];
    assign bus.out_valid = w_last.valid;
    assign bus.sum       = w_last.psum[WIDTH-1:0];
    assign bus.cout      = w_last.carry;

`ifdef PIPELINED_ADDER_OVF_EN
    // Signed overflow: operands share a sign and the result sign differs.
    // Operands travel with the payload, so ovf holds with sum under backpressure.
    assign bus.ovf = (w_last.a_rem[WIDTH-1] == w_last.b_rem[WIDTH-1]) &&
                     (w_last.psum[WIDTH-1]  != w_last.a_rem[WIDTH-1]);
`endif

    // Upper payload bits beyond WIDTH and spent operand bits are intentionally dropped.
    assign w_unused_bits = ^w_last;

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed bench for pipelined_adder (WIDTH=16, STAGES=4).
// Optional macro PIPELINED_ADDER_OVF_EN enables the ovf checks.
module tb_pipelined_adder;

    logic clk = 1'b0;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    pipelined_adder_if #(.WIDTH(16)) bus ();

    pipelined_adder #(.WIDTH(16), .STAGES(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic [15:0] exp_sum;
        logic        exp_cout;
        logic        exp_ovf;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_in;
        int n_out;

        //            a         b         cin   sub   sum       cout  ovf
        vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[1] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[3] = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0};
        vecs[4] = '{16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0};
        vecs[5] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vecs[6] = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};
        vecs[7] = '{16'h0FFF, 16'h0000, 1'b1, 1'b0, 16'h1000, 1'b0, 1'b0};
        vecs[8] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[9] = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};

        // Reset state
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.cin       = 1'b0;
        bus.sub       = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("reset_out_valid", 32'(bus.out_valid), 32'd0);
        check("reset_sum",       32'(bus.sum),       32'd0);
        check("reset_cout",      32'(bus.cout),      32'd0);
        check("reset_in_ready",  32'(bus.in_ready),  32'd1);
`ifdef PIPELINED_ADDER_OVF_EN
        check("reset_ovf",       32'(bus.ovf),       32'd0);
`endif

        // Single transactions: exact 4-cycle latency and result values
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.a        = vecs[i].a;
            bus.b        = vecs[i].b;
            bus.cin      = vecs[i].cin;
            bus.sub      = vecs[i].sub;
            for (int w = 0; w < 3; w++) begin
                @(negedge clk);
                bus.in_valid = 1'b0;
                check($sformatf("vec%0d_early_valid%0d", i, w), 32'(bus.out_valid), 32'd0);
            end
            @(negedge clk);
            check($sformatf("vec%0d_valid", i), 32'(bus.out_valid), 32'd1);
            check($sformatf("vec%0d_sum", i),   32'(bus.sum),       32'(vecs[i].exp_sum));
            check($sformatf("vec%0d_cout", i),  32'(bus.cout),      32'(vecs[i].exp_cout));
`ifdef PIPELINED_ADDER_OVF_EN
            check($sformatf("vec%0d_ovf", i),   32'(bus.ovf),       32'(vecs[i].exp_ovf));
`endif
        end

        // Back-to-back: 8 transfers, 8 consecutive results 0,2,...,14
        for (int cyc = 0; cyc < 13; cyc++) begin
            @(negedge clk);
            check($sformatf("b2b_valid%0d", cyc), 32'(bus.out_valid),
                  (cyc >= 4 && cyc < 12) ? 32'd1 : 32'd0);
            if (cyc >= 4 && cyc < 12)
                check($sformatf("b2b_sum%0d", cyc), 32'(bus.sum), 32'(2 * (cyc - 4)));
            bus.cin = 1'b0;
            bus.sub = 1'b0;
            if (cyc < 8) begin
                check($sformatf("b2b_in_ready%0d", cyc), 32'(bus.in_ready), 32'd1);
                bus.in_valid = 1'b1;
                bus.a        = 16'(cyc);
                bus.b        = 16'(cyc);
            end else begin
                bus.in_valid = 1'b0;
            end
        end

        // Backpressure: fill the pipe, stall 3 cycles, then drain 5 results
        n_in  = 0;
        n_out = 0;
        for (int cyc = 0; cyc < 40 && n_out < 5; cyc++) begin
            @(negedge clk);
            bus.out_ready = (cyc >= 7);
            bus.in_valid  = (n_in < 5);
            bus.a         = 16'h0100 + 16'(n_in);
            bus.b         = 16'h0010;
            #1;
            if (cyc >= 4 && cyc < 7) begin
                check($sformatf("stall_in_ready%0d", cyc),  32'(bus.in_ready),  32'd0);
                check($sformatf("stall_out_valid%0d", cyc), 32'(bus.out_valid), 32'd1);
                check($sformatf("stall_sum%0d", cyc),       32'(bus.sum),       32'h0110);
            end
            if (bus.out_valid && bus.out_ready) begin
                check($sformatf("drain_sum%0d", n_out), 32'(bus.sum), 32'h0110 + 32'(n_out));
                n_out++;
            end
            if (bus.in_valid && bus.in_ready)
                n_in++;
        end
        check("drain_count", 32'(n_out), 32'd5);
        bus.in_valid = 1'b0;
        for (int cyc = 0; cyc < 4; cyc++) begin
            @(negedge clk);
            check($sformatf("drain_empty%0d", cyc), 32'(bus.out_valid), 32'd0);
        end

        // Reset with three results in flight
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.a        = 16'h0A00 + 16'(i);
            bus.b        = 16'h0001;
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst_n        = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_sum",       32'(bus.sum),       32'd0);
        check("midrst_cout",      32'(bus.cout),      32'd0);
        check("midrst_in_ready",  32'(bus.in_ready),  32'd1);
`ifdef PIPELINED_ADDER_OVF_EN
        check("midrst_ovf",       32'(bus.ovf),       32'd0);
`endif
        for (int cyc = 0; cyc < 6; cyc++) begin
            @(negedge clk);
            check($sformatf("midrst_no_stale%0d", cyc), 32'(bus.out_valid), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipelined_adder.md
PIPELINED_ADDER -- requirements
Module: pipelined_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/result width in bits.
REQ-002 SHALL have parameter STAGES, default 4, pipeline depth; WIDTH SHALL be an integer multiple of STAGES, and CHUNK = WIDTH/STAGES.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1, the operand set is valid.
REQ-006 SHALL have port in_ready, output, 1, the block accepts operands this cycle.
REQ-007 SHALL have ports a and b, input, WIDTH, operands.
REQ-008 SHALL have port cin, input, 1, carry-in (add mode only).
REQ-009 SHALL have port sub, input, 1, 1 = subtract.
REQ-010 SHALL have port out_valid, output, 1, the result is valid.
REQ-011 SHALL have port out_ready, input, 1, the downstream accepts the result.
REQ-012 SHALL have port sum, output, WIDTH, the result modulo 2^WIDTH.
REQ-013 SHALL have port cout, output, 1, carry out of the MSB (in sub mode, 1 = no borrow).

Function
REQ-014 SHALL compute a+b+cin when sub=0 and a+~b+1 when sub=1; cin is ignored in sub mode.
REQ-015 Stage k SHALL add operand bits [k*CHUNK +: CHUNK] plus the registered carry from stage k-1, and register the partial sum, carry, and the not-yet-added upper operand bits.
REQ-016 The input transfer SHALL occur when in_valid && in_ready; the output transfer SHALL occur when out_valid && out_ready.
REQ-017 The pipeline SHALL advance all stages together when advance = !out_valid || out_ready; in_ready SHALL equal advance.
REQ-018 Latency SHALL be exactly STAGES cycles from the input transfer to out_valid under no backpressure; throughput SHALL be one result per cycle.
REQ-019 Each stage SHALL carry a valid bit; bubbles travel through the pipeline and are not compressed.
REQ-020 While out_valid && !out_ready, sum, cout, and out_valid SHALL hold stable and no internal stage SHALL change.
REQ-021 An output transfer and an input transfer in the same cycle SHALL both complete with no loss or duplication.
REQ-022 Results SHALL emerge in input order.

Reset
REQ-023 When rst_n=0 at a clock edge, all stage valid bits, out_valid, sum, cout, and ovf SHALL clear to 0, including mid-stream, and in-flight data SHALL be discarded.
REQ-024 in_ready SHALL be 1 in the first cycle after reset deasserts.

Configuration
REQ-025 With macro PIPELINED_ADDER_OVF_EN defined, the block SHALL have output port ovf (1 bit, aligned with sum) indicating two's-complement signed overflow of the selected operation; ovf SHALL also follow the hold behaviour in REQ-020.
REQ-026 Without PIPELINED_ADDER_OVF_EN, port ovf and its logic SHALL be absent; all other behaviour SHALL be unchanged.

Structure
REQ-027 Package adder_pkg SHALL hold the default WIDTH and STAGES constants and the stage payload struct (partial sum, carry, remaining a/b bits, valid).
REQ-028 One sub-module, adder_stage (CHUNK-bit add plus its register, with an enable), SHALL be instantiated STAGES times in a generate loop.

Verification (WIDTH=16, STAGES=4, out_ready=1 unless stated)
REQ-029 a=16'hFFFF, b=16'h0001, cin=0, sub=0 -> 4 cycles later sum=16'h0000, cout=1, ovf=0.
REQ-030 a=16'h0005, b=16'h0007, sub=1, cin=1 -> sum=16'hFFFE, cout=0, ovf=0 (cin ignored).
REQ-031 a=16'h7FFF, b=16'h0001, sub=0 -> sum=16'h8000, ovf=1 (macro on); the ovf port is absent when the macro is off.
REQ-032 8 back-to-back transfers with a=i, b=i -> out_valid high for 8 consecutive cycles starting 4 cycles after the first transfer; sums are 0,2,...,14 in order.
REQ-033 Pipeline full, out_ready=0 for 3 cycles -> in_ready=0, sum held stable; after release, all results delivered with none lost.
REQ-034 rst_n=0 for one edge with 3 results in flight -> next cycle out_valid=0, sum=0, in_ready=1, and no stale result ever appears.
